// File: rtl/pmem_line_adaptor_pkg.sv
// Shared types and defaults for the cache-line to DRAM-burst adaptor.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package pmem_adaptor_types;

  localparam int DEF_BEATS      = 4;
  localparam int DEF_BEAT_WIDTH = 64;
  localparam int DEF_LINE_WIDTH = 256;
  localparam int OFFSET_BITS    = 5;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    READ_BURST  = 2'd1,
    WRITE_BURST = 2'd2,
    DONE        = 2'd3
  } pmem_adaptor_state_t;

  // Clear the byte offset within a line so DRAM always sees line-aligned bursts.
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return addr & ~32'((1 << OFFSET_BITS) - 1);
  endfunction

endpackage

// File: rtl/pmem_line_adaptor_beat_buffer.sv
// Line-wide holding register plus beat counter; slices the line into bursts.
// Latency: load/beat writes visible the cycle after; beat_out is combinational.
// Backpressure: none; advance is only pulsed on an accepted beat.
module line_beat_buffer #(
  parameter int BEATS      = 4,
  parameter int BEAT_WIDTH = 64,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_line,
  input  logic [LINE_WIDTH-1:0] line_in,
  input  logic                  write_beat,
  input  logic [BEAT_WIDTH-1:0] beat_in,
  input  logic                  advance,
  input  logic                  clear,
  output logic [BEAT_WIDTH-1:0] beat_out,
  output logic [LINE_WIDTH-1:0] line_out,
  output logic                  last_beat
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [LINE_WIDTH-1:0] line_q;
  logic [CNT_W-1:0]      count;

  assign line_out  = line_q;
  assign beat_out  = line_q[int'(count) * BEAT_WIDTH +: BEAT_WIDTH];
  assign last_beat = (count == CNT_W'(BEATS - 1));

  // Whole-line load from the cache side, or one beat at a time from DRAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      line_q <= '0;
    end else if (load_line) begin
      line_q <= line_in;
    end else if (write_beat) begin
      line_q[int'(count) * BEAT_WIDTH +: BEAT_WIDTH] <= beat_in;
    end
  end

  // Beat index: wraps to zero after the last beat so the next line starts clean.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (advance) begin
      count <= last_beat ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pmem_line_adaptor.sv
// Responds to 256-bit cache line requests by running a 4-beat burst on the DRAM port.
// Latency: request seen at edge 0, burst cycles 1..4, mem_resp in cycle 5 (no stalls).
// Backpressure: burst_resp low stalls the burst in place; new requests wait in IDLE.
// Optional counters enabled by defining PMEM_ADAPTOR_PERF_EN.
module pmem_line_adaptor
  import pmem_adaptor_types::*;
#(
  parameter int BEATS      = DEF_BEATS,
  parameter int BEAT_WIDTH = DEF_BEAT_WIDTH,
  parameter int LINE_WIDTH = DEF_LINE_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           mem_addr,
  input  logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic                  mem_read,
  input  logic                  mem_write,
  output logic [LINE_WIDTH-1:0] mem_rdata,
  output logic                  mem_resp,
  output logic [31:0]           burst_addr,
  input  logic [BEAT_WIDTH-1:0] burst_rdata,
  output logic [BEAT_WIDTH-1:0] burst_wdata,
  output logic                  burst_read,
  output logic                  burst_write,
  input  logic                  burst_resp
`ifdef PMEM_ADAPTOR_PERF_EN
  ,
  output logic [31:0]           perf_line_reads,
  output logic [31:0]           perf_line_writes,
  output logic [31:0]           perf_stall_cycles
`endif
);

  generate
    if (LINE_WIDTH != BEATS * BEAT_WIDTH) begin : g_bad_cfg
      $error("pmem_line_adaptor: LINE_WIDTH must equal BEATS*BEAT_WIDTH");
    end
  endgenerate

  pmem_adaptor_state_t state;

  logic in_read;
  logic in_write;
  logic load_line;
  logic write_beat;
  logic advance;
  logic clear;
  logic last_beat;

  // Buffer control is decoded from the current state so the buffer and FSM move together.
  always_comb begin
    in_read    = (state == READ_BURST);
    in_write   = (state == WRITE_BURST);
    load_line  = (state == IDLE) && mem_write;
    write_beat = in_read && burst_resp;
    advance    = (in_read || in_write) && burst_resp;
    clear      = (state == IDLE);
  end

  line_beat_buffer #(
    .BEATS      (BEATS),
    .BEAT_WIDTH (BEAT_WIDTH),
    .LINE_WIDTH (LINE_WIDTH)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .load_line  (load_line),
    .line_in    (mem_wdata),
    .write_beat (write_beat),
    .beat_in    (burst_rdata),
    .advance    (advance),
    .clear      (clear),
    .beat_out   (burst_wdata),
    .line_out   (mem_rdata),
    .last_beat  (last_beat)
  );

  // Transaction FSM; command and response outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mem_resp    <= 1'b0;
      burst_read  <= 1'b0;
      burst_write <= 1'b0;
      burst_addr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          mem_resp <= 1'b0;
          // A write wins if the requester illegally raises both.
          if (mem_write) begin
            burst_addr  <= line_align(mem_addr);
            burst_write <= 1'b1;
            state       <= WRITE_BURST;
          end else if (mem_read) begin
            burst_addr  <= line_align(mem_addr);
            burst_read  <= 1'b1;
            state       <= READ_BURST;
          end
        end
        READ_BURST: begin
          if (burst_resp && last_beat) begin
            burst_read <= 1'b0;
            mem_resp   <= 1'b1;
            state      <= DONE;
          end
        end
        WRITE_BURST: begin
          if (burst_resp && last_beat) begin
            burst_write <= 1'b0;
            mem_resp    <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          mem_resp <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state       <= IDLE;
          mem_resp    <= 1'b0;
          burst_read  <= 1'b0;
          burst_write <= 1'b0;
        end
      endcase
    end
  end

`ifdef PMEM_ADAPTOR_PERF_EN
  // Saturating event counters: completed lines by type and stalled burst cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_line_reads   <= '0;
      perf_line_writes  <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (in_read && burst_resp && last_beat && (perf_line_reads != '1)) begin
        perf_line_reads <= perf_line_reads + 32'd1;
      end
      if (in_write && burst_resp && last_beat && (perf_line_writes != '1)) begin
        perf_line_writes <= perf_line_writes + 32'd1;
      end
      if ((in_read || in_write) && !burst_resp && (perf_stall_cycles != '1)) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pmem_line_adaptor.sv
// Directed bench for pmem_line_adaptor with a hand-driven DRAM beat responder.
// Latency: outputs sampled on the falling edge, inputs changed on the falling edge.
// Backpressure: burst_resp patterns are supplied per transaction.
module tb_pmem_line_adaptor;

  logic         clk;
  logic         reset;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic         mem_read;
  logic         mem_write;
  logic [255:0] mem_rdata;
  logic         mem_resp;
  logic [31:0]  burst_addr;
  logic [63:0]  burst_rdata;
  logic [63:0]  burst_wdata;
  logic         burst_read;
  logic         burst_write;
  logic         burst_resp;
`ifdef PMEM_ADAPTOR_PERF_EN
  logic [31:0]  perf_line_reads;
  logic [31:0]  perf_line_writes;
  logic [31:0]  perf_stall_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pmem_line_adaptor dut (
    .clk         (clk),
    .reset       (reset),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp),
    .burst_addr  (burst_addr),
    .burst_rdata (burst_rdata),
    .burst_wdata (burst_wdata),
    .burst_read  (burst_read),
    .burst_write (burst_write),
    .burst_resp  (burst_resp)
`ifdef PMEM_ADAPTOR_PERF_EN
    ,
    .perf_line_reads   (perf_line_reads),
    .perf_line_writes  (perf_line_writes),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one line request and act as DRAM until mem_resp. Starts and returns
  // just after a falling edge; on return the bench sits in the mem_resp cycle.
  task automatic do_txn(input string tag, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [255:0] wline,
                        input logic [255:0] rline, input logic [15:0] pat,
                        input int plen, input logic zero_mid, input logic hold_extra,
                        output int cmd_cycles, output int resp_cycle);
    int  beat;
    int  bi;
    bit  done;
    mem_read    = rd;
    mem_write   = wr;
    mem_addr    = addr;
    mem_wdata   = wline;
    burst_resp  = 1'b0;
    cmd_cycles  = 0;
    resp_cycle  = -1;
    beat        = 0;
    done        = 1'b0;
    for (int cyc = 1; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      bi = (beat > 3) ? 3 : beat;
      if (mem_resp) begin
        done       = 1'b1;
        resp_cycle = cyc;
        check_eq({tag, "_done_cmd"}, 256'({burst_write, burst_read}), 256'(2'b00));
        check_eq({tag, "_done_addr"}, 256'(burst_addr), 256'(addr & ~32'h1f));
      end else begin
        if (burst_read || burst_write) cmd_cycles++;
        check_eq({tag, "_cmd"}, 256'({burst_write, burst_read}), wr ? 256'(2'b10) : 256'(2'b01));
        check_eq({tag, "_addr"}, 256'(burst_addr), 256'(addr & ~32'h1f));
        if (wr) check_eq({tag, "_wdata"}, 256'(burst_wdata), 256'(wline[bi*64 +: 64]));
        if (zero_mid && cyc == 2) mem_wdata = '0;
        burst_resp  = (cyc - 1 < plen) ? pat[cyc-1] : 1'b1;
        burst_rdata = rline[bi*64 +: 64];
        if (burst_resp) beat++;
      end
    end
    if (!done) check_eq({tag, "_resp_timeout"}, 256'(0), 256'(1));
    burst_resp = 1'b0;
    if (!hold_extra) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  endtask

  logic [255:0] line_a, line_d, line_e, line_f, line_g;
  int cmd_n, resp_n;

  initial begin
    line_a = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    line_d = {64'hD3D3_D3D3_D3D3_D3D3, 64'hD2D2_D2D2_D2D2_D2D2,
              64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0};
    line_e = {64'hE3E3_0000_0000_0003, 64'hE2E2_0000_0000_0002,
              64'hE1E1_0000_0000_0001, 64'hE0E0_0000_0000_0000};
    line_f = {64'hF3F3_F3F3_F3F3_F3F3, 64'hF2F2_F2F2_F2F2_F2F2,
              64'hF1F1_F1F1_F1F1_F1F1, 64'hF0F0_F0F0_F0F0_F0F0};
    line_g = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
              64'h5A5A_5A5A_A5A5_A5A5, 64'h0F0F_F0F0_0F0F_F0F0};

    reset = 1'b1; mem_addr = '0; mem_wdata = '0; mem_read = 1'b0; mem_write = 1'b0;
    burst_rdata = '0; burst_resp = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_mem_resp", 256'(mem_resp), 256'(0));
    check_eq("rst_cmd", 256'({burst_write, burst_read}), 256'(0));
    check_eq("rst_addr", 256'(burst_addr), 256'(0));
    check_eq("rst_wdata", 256'(burst_wdata), 256'(0));
    check_eq("rst_rdata", mem_rdata, 256'(0));
`ifdef PMEM_ADAPTOR_PERF_EN
    check_eq("rst_perf", 256'({perf_line_reads, perf_line_writes, perf_stall_cycles}), 256'(0));
`endif
    reset = 1'b0;
    @(negedge clk);

    // Read with back-to-back beats.
    do_txn("rd", 1'b1, 1'b0, 32'h0000_1234, '0, line_a, 16'hFFFF, 4, 1'b0, 1'b0, cmd_n, resp_n);
    check_eq("rd_cmd_cycles", 256'(cmd_n), 256'(4));
    check_eq("rd_resp_cycle", 256'(resp_n), 256'(5));
    check_eq("rd_addr_val", 256'(burst_addr), 256'(32'h0000_1220));
    check_eq("rd_line", mem_rdata, line_a);
    @(negedge clk);
    check_eq("rd_resp_pulse", 256'(mem_resp), 256'(0));
    check_eq("rd_line_hold", mem_rdata, line_a);

    // Write with stall pattern 1,0,0,1,1,0,1.
    do_txn("wr", 1'b0, 1'b1, 32'h8000_0040, line_d, '0, 16'h0059, 7, 1'b0, 1'b0, cmd_n, resp_n);
    check_eq("wr_cmd_cycles", 256'(cmd_n), 256'(7));
    check_eq("wr_resp_cycle", 256'(resp_n), 256'(8));
    @(negedge clk);
    check_eq("wr_resp_pulse", 256'(mem_resp), 256'(0));
`ifdef PMEM_ADAPTOR_PERF_EN
    check_eq("perf_stalls", 256'(perf_stall_cycles), 256'(3));
    check_eq("perf_writes", 256'(perf_line_writes), 256'(1));
`endif

    // Both requests raised: write wins.
    do_txn("both", 1'b1, 1'b1, 32'h0000_2000, line_f, line_a, 16'hFFFF, 4, 1'b0, 1'b0, cmd_n, resp_n);
    check_eq("both_resp_cycle", 256'(resp_n), 256'(5));
    @(negedge clk);
    check_eq("both_resp_pulse", 256'(mem_resp), 256'(0));
    @(negedge clk);
    check_eq("both_idle_cmd", 256'({burst_write, burst_read}), 256'(0));

    // Write data changes to zero mid-burst; DRAM must still see the latched line.
    do_txn("wrz", 1'b0, 1'b1, 32'h0000_3000, line_e, '0, 16'hFFFF, 4, 1'b1, 1'b0, cmd_n, resp_n);
    check_eq("wrz_resp_cycle", 256'(resp_n), 256'(5));
    @(negedge clk);

    // Reset after three read beats have transferred.
    mem_read = 1'b1; mem_addr = 32'h0000_4000; burst_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      burst_resp  = 1'b1;
      burst_rdata = line_g[i*64 +: 64];
    end
    @(negedge clk);
    reset = 1'b1; burst_resp = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    check_eq("rstmid_cmd", 256'({burst_write, burst_read}), 256'(0));
    check_eq("rstmid_resp", 256'(mem_resp), 256'(0));
    check_eq("rstmid_rdata", mem_rdata, 256'(0));
    reset = 1'b0;
    @(negedge clk);
    check_eq("rstmid_resp2", 256'(mem_resp), 256'(0));

    // Stray burst_resp in IDLE changes nothing.
    burst_resp = 1'b1; burst_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    repeat (2) @(negedge clk);
    check_eq("idle_resp_rdata", mem_rdata, 256'(0));
    check_eq("idle_resp_cmd", 256'({burst_write, burst_read, mem_resp}), 256'(0));
    burst_resp = 1'b0;

    // Read held one cycle past mem_resp: a second identical read follows.
    do_txn("hold1", 1'b1, 1'b0, 32'h0000_5010, '0, line_g, 16'hFFFF, 4, 1'b0, 1'b1, cmd_n, resp_n);
    check_eq("hold1_resp_cycle", 256'(resp_n), 256'(5));
    check_eq("hold1_line", mem_rdata, line_g);
    @(negedge clk);
    check_eq("hold1_resp_pulse", 256'(mem_resp), 256'(0));
    do_txn("hold2", 1'b1, 1'b0, 32'h0000_5010, '0, line_f, 16'hFFFF, 4, 1'b0, 1'b0, cmd_n, resp_n);
    check_eq("hold2_resp_cycle", 256'(resp_n), 256'(5));
    check_eq("hold2_line", mem_rdata, line_f);
`ifdef PMEM_ADAPTOR_PERF_EN
    check_eq("perf_reads", 256'(perf_line_reads), 256'(2));
`endif
    @(negedge clk);
    check_eq("hold2_resp_pulse", 256'(mem_resp), 256'(0));
    @(negedge clk);
    check_eq("hold2_idle_cmd", 256'({burst_write, burst_read}), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
